// File: rtl/core_debug_host_pkg.sv
// -----------------------------------------------------------------------------
// core_debug_host_pkg
// Shared definitions for the core debug host byte-stream front end:
//   - FSM state encoding (RX / ISSUE / WAIT / TX)
//   - response STATUS byte codes
//   - command / response frame lengths and widths
//   - helper to assemble a response frame
// No ports (package).
// -----------------------------------------------------------------------------
package core_debug_host_pkg;

    typedef enum logic [1:0] {
        ST_RX    = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_TX    = 2'd3
    } state_e;

    localparam logic [7:0] STATUS_OK  = 8'hA0;
    localparam logic [7:0] STATUS_ERR = 8'hE1;
    localparam logic [7:0] STATUS_TMO = 8'hE2;

    localparam int unsigned CMD_LEN  = 6;
    localparam int unsigned RESP_LEN = 5;
    localparam int unsigned CMD_W    = CMD_LEN * 8;
    localparam int unsigned RESP_W   = RESP_LEN * 8;

    function automatic logic [RESP_W-1:0] pack_resp(input logic [7:0]  status,
                                                    input logic [31:0] data);
        return {status, data};
    endfunction

endpackage

// File: rtl/core_debug_host_tx.sv
// -----------------------------------------------------------------------------
// core_debug_host_tx
// Response serialiser: loads a 40-bit response frame and shifts it out
// MSB-first, one byte per accepted handshake. Valid is owned by the top FSM
// (active_i); this block only holds the byte and reports the final accept.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   load_i     load frame_i and restart the byte counter
//   frame_i    40-bit response {STATUS, DATA[31:0]}
//   active_i   top FSM is in TX (byte is being offered)
//   ready_i    host sink ready
//   data_o     current response byte (registered)
//   done_o     last byte accepted this cycle
// -----------------------------------------------------------------------------
module core_debug_host_tx
    import core_debug_host_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [RESP_W-1:0] frame_i,
    input  logic              active_i,
    input  logic              ready_i,
    output logic [7:0]        data_o,
    output logic              done_o
);

    logic [RESP_W-1:0] sh_q;
    logic [2:0]        cnt_q;
    logic              last;

    assign last   = (cnt_q == 3'(RESP_LEN - 1));
    assign done_o = active_i && ready_i && last;
    assign data_o = sh_q[RESP_W-1 -: 8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sh_q  <= frame_i;
            cnt_q <= '0;
        end else if (active_i && ready_i) begin
            sh_q  <= {sh_q[RESP_W-9:0], 8'h00};
            cnt_q <= last ? 3'd0 : cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/core_debug_host_if.sv
// -----------------------------------------------------------------------------
// core_debug_host_if
// Byte-stream front end for the core debug unit. Deframes 6-byte command
// packets, issues one command on the request/busy interface, captures the
// response and returns a 5-byte {STATUS, DATA} frame.
// Optional feature macro: PROCESSOR_DEBUG_HOST_TIMEOUT_EN adds a response
// timeout (STATUS E2, DATA 0) after P_TIMEOUT_CYCLES cycles in WAIT.
// Ports:
//   iCLOCK, inRESET                       clock, async active-low reset
//   iRX_VALID/oRX_READY/iRX_DATA          host command byte channel
//   oTX_VALID/iTX_READY/oTX_DATA          host response byte channel
//   oCMD_REQ/iCMD_BUSY                    command request handshake
//   oCMD_COMMAND/oCMD_TARGET/oCMD_DATA    command fields
//   iRESP_VALID/iRESP_ERROR/iRESP_DATA    response strobe and payload
//
// state  | meaning
// -------+-----------------------------------------------------------
// RX     | accepting command bytes 0..5
// ISSUE  | oCMD_REQ high until the debug unit is not busy
// WAIT   | waiting for iRESP_VALID (or timeout when compiled in)
// TX     | sending the 5 response bytes
// -----------------------------------------------------------------------------
module core_debug_host_if
    import core_debug_host_pkg::*;
#(
    parameter int unsigned P_TIMEOUT_CYCLES = 1024
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRX_VALID,
    output logic        oRX_READY,
    input  logic [7:0]  iRX_DATA,
    output logic        oTX_VALID,
    input  logic        iTX_READY,
    output logic [7:0]  oTX_DATA,
    output logic        oCMD_REQ,
    input  logic        iCMD_BUSY,
    output logic [3:0]  oCMD_COMMAND,
    output logic [11:0] oCMD_TARGET,
    output logic [31:0] oCMD_DATA,
    input  logic        iRESP_VALID,
    input  logic        iRESP_ERROR,
    input  logic [31:0] iRESP_DATA
);

    if (P_TIMEOUT_CYCLES < 2 || P_TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("core_debug_host_if: P_TIMEOUT_CYCLES must be 2..65535");
    end

    state_e             state_q, state_d;
    logic [2:0]         rx_cnt_q;
    logic [CMD_W-1:0]   cmd_q;
    logic               rx_last;
    logic               resp_load;
    logic [RESP_W-1:0]  resp_frame;
    logic               tx_done;

    assign rx_last = (state_q == ST_RX) && iRX_VALID && (rx_cnt_q == 3'(CMD_LEN - 1));

    // Command register doubles as the command output register; fields only
    // move while bytes are shifted in, so they are stable from ISSUE to TX.
    assign oCMD_COMMAND = cmd_q[47:44];
    assign oCMD_TARGET  = cmd_q[43:32];
    assign oCMD_DATA    = cmd_q[31:0];

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rx_cnt_q <= '0;
            cmd_q    <= '0;
        end else if (state_q == ST_RX && iRX_VALID) begin
            cmd_q    <= {cmd_q[CMD_W-9:0], iRX_DATA};
            rx_cnt_q <= rx_last ? 3'd0 : rx_cnt_q + 3'd1;
        end
    end

`ifdef PROCESSOR_DEBUG_HOST_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        tmo_expired;

    // Held at zero in ISSUE so counting starts fresh on the first WAIT cycle.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            tmo_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            tmo_q <= '0;
        end else if (state_q == ST_WAIT) begin
            tmo_q <= tmo_q + 16'd1;
        end
    end

    assign tmo_expired = (tmo_q == 16'(P_TIMEOUT_CYCLES - 1));
`endif

    // A real response has priority over a coincident timeout.
    always_comb begin
        resp_load  = 1'b0;
        resp_frame = '0;
        if (state_q == ST_WAIT) begin
            if (iRESP_VALID) begin
                resp_load  = 1'b1;
                resp_frame = pack_resp(iRESP_ERROR ? STATUS_ERR : STATUS_OK, iRESP_DATA);
            end
`ifdef PROCESSOR_DEBUG_HOST_TIMEOUT_EN
            else if (tmo_expired) begin
                resp_load  = 1'b1;
                resp_frame = pack_resp(STATUS_TMO, 32'h0);
            end
`endif
        end
    end

    core_debug_host_tx u_tx (
        .clk_i    (iCLOCK),
        .rst_ni   (inRESET),
        .load_i   (resp_load),
        .frame_i  (resp_frame),
        .active_i (state_q == ST_TX),
        .ready_i  (iTX_READY),
        .data_o   (oTX_DATA),
        .done_o   (tx_done)
    );

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= ST_RX;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RX:    if (rx_last)    state_d = ST_ISSUE;
            ST_ISSUE: if (!iCMD_BUSY) state_d = ST_WAIT;
            ST_WAIT:  if (resp_load)  state_d = ST_TX;
            ST_TX:    if (tx_done)    state_d = ST_RX;
            default:                  state_d = ST_RX;
        endcase
    end

    always_comb begin
        oRX_READY = (state_q == ST_RX);
        oCMD_REQ  = (state_q == ST_ISSUE);
        oTX_VALID = (state_q == ST_TX);
    end

endmodule

// File: tb/tb_core_debug_host_if.sv
module tb_core_debug_host_if;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iRX_VALID;
    logic        oRX_READY;
    logic [7:0]  iRX_DATA;
    logic        oTX_VALID;
    logic        iTX_READY;
    logic [7:0]  oTX_DATA;
    logic        oCMD_REQ;
    logic        iCMD_BUSY;
    logic [3:0]  oCMD_COMMAND;
    logic [11:0] oCMD_TARGET;
    logic [31:0] oCMD_DATA;
    logic        iRESP_VALID;
    logic        iRESP_ERROR;
    logic [31:0] iRESP_DATA;

    core_debug_host_if #(.P_TIMEOUT_CYCLES(16)) dut (
        .iCLOCK       (iCLOCK),
        .inRESET      (inRESET),
        .iRX_VALID    (iRX_VALID),
        .oRX_READY    (oRX_READY),
        .iRX_DATA     (iRX_DATA),
        .oTX_VALID    (oTX_VALID),
        .iTX_READY    (iTX_READY),
        .oTX_DATA     (oTX_DATA),
        .oCMD_REQ     (oCMD_REQ),
        .iCMD_BUSY    (iCMD_BUSY),
        .oCMD_COMMAND (oCMD_COMMAND),
        .oCMD_TARGET  (oCMD_TARGET),
        .oCMD_DATA    (oCMD_DATA),
        .iRESP_VALID  (iRESP_VALID),
        .iRESP_ERROR  (iRESP_ERROR),
        .iRESP_DATA   (iRESP_DATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct packed {
        logic [47:0] frame;
        int          busy;
        int          delay;    // WAIT cycles before the strobe, or expected timeout WAIT length
        bit          no_resp;
        bit          err;
        logic [31:0] rdata;
        bit          bp;
        logic [3:0]  e_cmd;
        logic [11:0] e_tgt;
        logic [31:0] e_data;
        logic [39:0] e_tx;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int n_take = 0;
    int n_req_cyc = 0;
    vec_t vecs[$];

    always @(posedge iCLOCK) begin
        if (inRESET && oCMD_REQ) n_req_cyc++;
        if (inRESET && oCMD_REQ && !iCMD_BUSY) n_take++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] f, input int busy, input int delay,
                                input bit nr, input bit err, input logic [31:0] rd,
                                input bit bp, input logic [3:0] c, input logic [11:0] t,
                                input logic [31:0] d, input logic [39:0] tx);
        vec_t v;
        v.frame = f; v.busy = busy; v.delay = delay; v.no_resp = nr; v.err = err;
        v.rdata = rd; v.bp = bp; v.e_cmd = c; v.e_tgt = t; v.e_data = d; v.e_tx = tx;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        iRX_VALID = 1'b1;
        iRX_DATA  = b;
        while (!oRX_READY && guard < 200) begin
            @(posedge iCLOCK); @(negedge iCLOCK);
            guard++;
        end
        if (guard >= 200) chk("rx_ready_timeout", 64'(oRX_READY), 64'd1);
        @(posedge iCLOCK); @(negedge iCLOCK);
        iRX_VALID = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int w;
        int idx;
        int guard;
        bit rdy;
        n_take    = 0;
        n_req_cyc = 0;
        for (int i = 0; i < 6; i++) send_byte(v.frame[47-8*i -: 8]);

        chk("req_rise", 64'(oCMD_REQ), 64'd1);
        chk("rx_ready_issue", 64'(oRX_READY), 64'd0);
        chk("cmd_fields", 64'({oCMD_COMMAND, oCMD_TARGET, oCMD_DATA}),
            64'({v.e_cmd, v.e_tgt, v.e_data}));

        // Busy stall; a stray response strobe during ISSUE must be ignored.
        for (int i = 0; i < v.busy; i++) begin
            iCMD_BUSY   = 1'b1;
            iRESP_VALID = 1'b1;
            iRESP_DATA  = 32'hBAD0BAD0;
            @(posedge iCLOCK); @(negedge iCLOCK);
            chk("req_hold", 64'(oCMD_REQ), 64'd1);
            chk("cmd_stable", 64'({oCMD_COMMAND, oCMD_TARGET, oCMD_DATA}),
                64'({v.e_cmd, v.e_tgt, v.e_data}));
        end
        iCMD_BUSY   = 1'b0;
        iRESP_VALID = 1'b0;
        @(posedge iCLOCK); @(negedge iCLOCK);
        chk("req_fall", 64'(oCMD_REQ), 64'd0);
        chk("take_count", 64'(n_take), 64'd1);
        chk("req_cycles", 64'(n_req_cyc), 64'(v.busy + 1));

        if (!v.no_resp) begin
            for (int i = 0; i < v.delay; i++) begin
                chk("tx_idle_wait", 64'(oTX_VALID), 64'd0);
                @(posedge iCLOCK); @(negedge iCLOCK);
            end
            iRESP_VALID = 1'b1;
            iRESP_ERROR = v.err;
            iRESP_DATA  = v.rdata;
            @(posedge iCLOCK); @(negedge iCLOCK);
            iRESP_VALID = 1'b0;
            iRESP_ERROR = 1'b0;
            chk("tx_valid_rise", 64'(oTX_VALID), 64'd1);
        end else begin
            w = 0;
            while (!oTX_VALID && w < 200) begin
                chk("rx_ready_wait", 64'(oRX_READY), 64'd0);
                w++;
                @(posedge iCLOCK); @(negedge iCLOCK);
            end
            chk("timeout_wait_cycles", 64'(w), 64'(v.delay));
        end

        idx   = 0;
        guard = 0;
        rdy   = !v.bp;
        while (idx < 5 && guard < 100) begin
            chk("tx_valid", 64'(oTX_VALID), 64'd1);
            chk("tx_byte", 64'(oTX_DATA), 64'(v.e_tx[39-8*idx -: 8]));
            chk("rx_ready_tx", 64'(oRX_READY), 64'd0);
            iTX_READY = rdy;
            @(posedge iCLOCK); @(negedge iCLOCK);
            if (rdy) idx++;
            if (v.bp) rdy = !rdy;
            guard++;
        end
        iTX_READY = 1'b0;
        chk("tx_count", 64'(idx), 64'd5);
        chk("tx_valid_fall", 64'(oTX_VALID), 64'd0);
        chk("rx_ready_back", 64'(oRX_READY), 64'd1);
    endtask

    initial begin
        inRESET     = 1'b0;
        iRX_VALID   = 1'b0;
        iRX_DATA    = 8'h00;
        iTX_READY   = 1'b0;
        iCMD_BUSY   = 1'b0;
        iRESP_VALID = 1'b0;
        iRESP_ERROR = 1'b0;
        iRESP_DATA  = 32'h0;

        vecs.push_back(mk(48'h00_05_00_00_00_00, 0, 3, 0, 0, 32'hDEADBEEF, 0,
                          4'h0, 12'h005, 32'h0000_0000, 40'hA0_DE_AD_BE_EF));
        vecs.push_back(mk(48'h2A_BC_11_22_33_44, 4, 0, 0, 0, 32'hCAFEF00D, 0,
                          4'h2, 12'hABC, 32'h1122_3344, 40'hA0_CA_FE_F0_0D));
        vecs.push_back(mk(48'h37_FF_00_00_00_01, 0, 1, 0, 1, 32'h12345678, 0,
                          4'h3, 12'h7FF, 32'h0000_0001, 40'hE1_12_34_56_78));
        vecs.push_back(mk(48'h9F_0E_A5_5A_C3_3C, 1, 2, 0, 0, 32'h01020304, 1,
                          4'h9, 12'hF0E, 32'hA55A_C33C, 40'hA0_01_02_03_04));
        vecs.push_back(mk(48'hF1_23_FF_FF_FF_FF, 0, 0, 0, 0, 32'h00000000, 0,
                          4'hF, 12'h123, 32'hFFFF_FFFF, 40'hA0_00_00_00_00));
`ifdef PROCESSOR_DEBUG_HOST_TIMEOUT_EN
        vecs.push_back(mk(48'hF0_00_00_00_00_00, 0, 16, 1, 0, 32'h0, 0,
                          4'hF, 12'h000, 32'h0000_0000, 40'hE2_00_00_00_00));
`endif

        repeat (3) @(posedge iCLOCK);
        @(negedge iCLOCK);
        chk("rst_rx_ready", 64'(oRX_READY), 64'd1);
        chk("rst_tx", 64'({oTX_VALID, oTX_DATA}), 64'd0);
        chk("rst_cmd", 64'({oCMD_REQ, oCMD_COMMAND, oCMD_TARGET, oCMD_DATA}), 64'd0);
        inRESET = 1'b1;
        @(posedge iCLOCK); @(negedge iCLOCK);
        chk("post_rst_rx_ready", 64'(oRX_READY), 64'd1);

        for (int i = 0; i < vecs.size(); i++) run_frame(vecs[i]);

        // Reset after three bytes of a frame, then a complete new frame.
        send_byte(8'h3C);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("partial_no_req", 64'(oCMD_REQ), 64'd0);
        inRESET = 1'b0;
        @(posedge iCLOCK); @(negedge iCLOCK);
        chk("midrst_state", 64'({oRX_READY, oTX_VALID, oCMD_REQ}), 64'b100);
        chk("midrst_cmd", 64'({oCMD_COMMAND, oCMD_TARGET, oCMD_DATA}), 64'd0);
        inRESET = 1'b1;
        @(posedge iCLOCK); @(negedge iCLOCK);
        run_frame(mk(48'h5A_BC_DE_F0_12_34, 0, 0, 0, 0, 32'h0BADF00D, 0,
                     4'h5, 12'hABC, 32'hDEF0_1234, 40'hA0_0B_AD_F0_0D));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
